// File: rtl/bidn_round_ctrl.sv
// bidn_round_ctrl -- N-bidder auction round controller.
//
// The host configures balances, round length, bidder mask and per-bid fee
// through C_op/C_data while the controller is unlocked. It then locks the
// controller with a key and starts timed bidding rounds with C_start.
// Each bidding cycle resolves any number of same-cycle bids and retracts.
// At the end of the round a one-cycle settle charges the winner its bid.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   C_data, C_op        command operand / opcode, sampled every cycle
//   C_start             round start request, honoured only in LOCKED_IDLE
//   bid_valid/bid_amt   per-bidder bid strobe and flattened amounts (slice i)
//   bid_retract         per-bidder retract strobe
//   bid_ack/bid_nak     per-bidder accept / reject, one cycle after the bid
//   balance             flattened current balances
//   ready               high while locked and idle
//   round_over          one-cycle pulse during settle
//   win_valid, win_idx  winner of the last round, held until the next start
//   max_bid             running maximum during a round, final value after it
//   err                 registered command error code, valid for one cycle
module bidn_round_ctrl #(
  parameter int NUM_BIDDERS = 3,
  parameter int DATA_W      = 32,
  parameter int VALUE_W     = 16,
  parameter int TIMER_W     = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DATA_W-1:0]                C_data,
  input  logic [3:0]                       C_op,
  input  logic                             C_start,
  input  logic [NUM_BIDDERS-1:0]           bid_valid,
  input  logic [NUM_BIDDERS*VALUE_W-1:0]   bid_amt,
  input  logic [NUM_BIDDERS-1:0]           bid_retract,
  output logic [NUM_BIDDERS-1:0]           bid_ack,
  output logic [NUM_BIDDERS-1:0]           bid_nak,
  output logic [NUM_BIDDERS*VALUE_W-1:0]   balance,
  output logic                             ready,
  output logic                             round_over,
  output logic                             win_valid,
  output logic [$clog2(NUM_BIDDERS)-1:0]   win_idx,
  output logic [VALUE_W-1:0]               max_bid,
  output logic [2:0]                       err
);
  localparam int IDX_W = $clog2(NUM_BIDDERS);
  localparam int SEL_W = DATA_W - VALUE_W;

  typedef enum logic [1:0] {
    S_UNLOCKED, S_LOCKED_IDLE, S_BIDDING, S_SETTLE
  } state_t;

  state_t                 state_reg, state_next;
  logic [DATA_W-1:0]      key_reg, key_next;
  logic [TIMER_W-1:0]     timer_cfg_reg, timer_cfg_next;
  logic [TIMER_W-1:0]     cnt_reg, cnt_next;
  logic [VALUE_W-1:0]     fee_reg, fee_next;
  logic [NUM_BIDDERS-1:0] mask_reg, mask_next;
  logic [VALUE_W-1:0]     bal_reg [NUM_BIDDERS];
  logic [VALUE_W-1:0]     bal_next [NUM_BIDDERS];
  logic                   lead_valid_reg, lead_valid_next;
  logic [IDX_W-1:0]       lead_idx_reg, lead_idx_next;
  logic [VALUE_W-1:0]     max_bid_reg, max_bid_next;
  logic                   win_valid_reg, win_valid_next;
  logic [IDX_W-1:0]       win_idx_reg, win_idx_next;
  logic [2:0]             err_reg, err_next;
  logic [NUM_BIDDERS-1:0] ack_reg, ack_next;
  logic [NUM_BIDDERS-1:0] nak_reg, nak_next;

  logic [VALUE_W-1:0]     amt [NUM_BIDDERS];
  logic [NUM_BIDDERS-1:0] elig;
  logic                   best_found;
  logic [IDX_W-1:0]       best_idx;
  logic [VALUE_W-1:0]     best_amt;
  logic [SEL_W-1:0]       set_sel;

  assign set_sel = C_data[DATA_W-1:VALUE_W];

  // Funds check is done one bit wider so amt + fee can never wrap.
  for (genvar gi = 0; gi < NUM_BIDDERS; gi++) begin : g_bidder
    assign amt[gi]  = bid_amt[gi*VALUE_W +: VALUE_W];
    assign elig[gi] = bid_valid[gi] && mask_reg[gi] && (amt[gi] > max_bid_reg) &&
                      ({1'b0, bal_reg[gi]} >= ({1'b0, amt[gi]} + {1'b0, fee_reg}));
    assign balance[gi*VALUE_W +: VALUE_W] = bal_reg[gi];
  end

  // Cycle winner: strict '>' while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_found = 1'b0;
    best_idx   = '0;
    best_amt   = '0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (elig[i] && (!best_found || amt[i] > best_amt)) begin
        best_found = 1'b1;
        best_idx   = IDX_W'(i);
        best_amt   = amt[i];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    key_next        = key_reg;
    timer_cfg_next  = timer_cfg_reg;
    cnt_next        = cnt_reg;
    fee_next        = fee_reg;
    mask_next       = mask_reg;
    bal_next        = bal_reg;
    lead_valid_next = lead_valid_reg;
    lead_idx_next   = lead_idx_reg;
    max_bid_next    = max_bid_reg;
    win_valid_next  = win_valid_reg;
    win_idx_next    = win_idx_reg;
    err_next        = 3'd0;
    ack_next        = '0;
    nak_next        = '0;

    // Command port. Configuration opcodes only take effect while unlocked;
    // during a round every command is inert apart from its error code.
    case (C_op)
      4'd0: ;
      4'd1: begin
        if (state_reg == S_BIDDING || state_reg == S_SETTLE) err_next = 3'd1;
        else if (C_data == key_reg) state_next = S_UNLOCKED;
        else err_next = 3'd3;
      end
      4'd2: begin
        if (state_reg != S_UNLOCKED) err_next = 3'd1;
        else begin
          key_next   = C_data;
          state_next = S_LOCKED_IDLE;
        end
      end
      4'd3: begin
        if (state_reg != S_UNLOCKED) err_next = 3'd1;
        else if (set_sel >= SEL_W'(NUM_BIDDERS)) err_next = 3'd4;
        else bal_next[set_sel[IDX_W-1:0]] = C_data[VALUE_W-1:0];
      end
      4'd4: begin
        if (state_reg != S_UNLOCKED) err_next = 3'd1;
        else timer_cfg_next = C_data[TIMER_W-1:0];
      end
      4'd5: begin
        if (state_reg != S_UNLOCKED) err_next = 3'd1;
        else mask_next = C_data[NUM_BIDDERS-1:0];
      end
      4'd6: begin
        if (state_reg != S_UNLOCKED) err_next = 3'd1;
        else fee_next = C_data[VALUE_W-1:0];
      end
      default: err_next = 3'd2;
    endcase

    if (state_reg == S_LOCKED_IDLE && C_start) begin
      if (timer_cfg_reg == '0) err_next = 3'd5;
      else begin
        state_next      = S_BIDDING;
        cnt_next        = timer_cfg_reg;
        max_bid_next    = '0;
        lead_valid_next = 1'b0;
        lead_idx_next   = '0;
        win_valid_next  = 1'b0;
        win_idx_next    = '0;
      end
    end

    if (state_reg == S_BIDDING) begin
      // Retracts first; a same-cycle winning bid then overrides the cleared
      // leader, since all bids were judged against the pre-retract max_bid.
      for (int i = 0; i < NUM_BIDDERS; i++) begin
        if (bid_valid[i] && !elig[i]) nak_next[i] = 1'b1;
        if (bid_retract[i]) begin
          if (lead_valid_reg && lead_idx_reg == IDX_W'(i) && !bid_valid[i]) begin
            max_bid_next    = '0;
            lead_valid_next = 1'b0;
          end else begin
            nak_next[i] = 1'b1;
          end
        end
        if (elig[i]) begin
          if (best_idx == IDX_W'(i)) ack_next[i] = 1'b1;
          else nak_next[i] = 1'b1;
        end
      end
      if (best_found) begin
        bal_next[best_idx] = bal_reg[best_idx] - fee_reg;
        max_bid_next       = best_amt;
        lead_valid_next    = 1'b1;
        lead_idx_next      = best_idx;
      end
      cnt_next = cnt_reg - TIMER_W'(1);
      if (cnt_reg <= TIMER_W'(1)) state_next = S_SETTLE;
    end

    if (state_reg == S_SETTLE) begin
      state_next = S_LOCKED_IDLE;
      if (lead_valid_reg) begin
        bal_next[lead_idx_reg] = bal_reg[lead_idx_reg] - max_bid_reg;
        win_valid_next         = 1'b1;
        win_idx_next           = lead_idx_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_UNLOCKED;
      key_reg        <= '0;
      timer_cfg_reg  <= '0;
      cnt_reg        <= '0;
      fee_reg        <= '0;
      mask_reg       <= '1;
      bal_reg        <= '{default: '0};
      lead_valid_reg <= 1'b0;
      lead_idx_reg   <= '0;
      max_bid_reg    <= '0;
      win_valid_reg  <= 1'b0;
      win_idx_reg    <= '0;
      err_reg        <= 3'd0;
      ack_reg        <= '0;
      nak_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      key_reg        <= key_next;
      timer_cfg_reg  <= timer_cfg_next;
      cnt_reg        <= cnt_next;
      fee_reg        <= fee_next;
      mask_reg       <= mask_next;
      bal_reg        <= bal_next;
      lead_valid_reg <= lead_valid_next;
      lead_idx_reg   <= lead_idx_next;
      max_bid_reg    <= max_bid_next;
      win_valid_reg  <= win_valid_next;
      win_idx_reg    <= win_idx_next;
      err_reg        <= err_next;
      ack_reg        <= ack_next;
      nak_reg        <= nak_next;
    end
  end

  assign bid_ack    = ack_reg;
  assign bid_nak    = nak_reg;
  assign ready      = (state_reg == S_LOCKED_IDLE);
  assign round_over = (state_reg == S_SETTLE);
  assign win_valid  = win_valid_reg;
  assign win_idx    = win_idx_reg;
  assign max_bid    = max_bid_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_bidn_round_ctrl.sv
// Directed bench for bidn_round_ctrl (3 bidders, 16-bit values).
module tb_bidn_round_ctrl;
  localparam int NB = 3;
  localparam int DW = 32;
  localparam int VW = 16;
  localparam int TW = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [DW-1:0]  C_data = '0;
  logic [3:0]     C_op = '0;
  logic           C_start = 1'b0;
  logic [NB-1:0]  bid_valid = '0;
  logic [NB*VW-1:0] bid_amt = '0;
  logic [NB-1:0]  bid_retract = '0;
  logic [NB-1:0]  bid_ack, bid_nak;
  logic [NB*VW-1:0] balance;
  logic           ready, round_over, win_valid;
  logic [1:0]     win_idx;
  logic [VW-1:0]  max_bid;
  logic [2:0]     err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bidn_round_ctrl #(.NUM_BIDDERS(NB), .DATA_W(DW), .VALUE_W(VW), .TIMER_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .C_data(C_data), .C_op(C_op), .C_start(C_start),
    .bid_valid(bid_valid), .bid_amt(bid_amt), .bid_retract(bid_retract),
    .bid_ack(bid_ack), .bid_nak(bid_nak), .balance(balance), .ready(ready),
    .round_over(round_over), .win_valid(win_valid), .win_idx(win_idx),
    .max_bid(max_bid), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] bal(input int i);
    return balance[i*VW +: VW];
  endfunction

  task automatic cmd(input logic [3:0] op, input logic [DW-1:0] data);
    C_op = op;
    C_data = data;
    tick();
    C_op = '0;
    C_data = '0;
    $display("cmd op=%0d data=0x%0h -> err=%0d ready=%0b", op, data, err, ready);
  endtask

  task automatic bid(input int i, input logic [VW-1:0] a);
    bid_valid[i] = 1'b1;
    bid_amt[i*VW +: VW] = a;
  endtask

  task automatic bid_cycle();
    tick();
    $display("bid valid=%b retract=%b -> ack=%b nak=%b max_bid=%0d",
             bid_valid, bid_retract, bid_ack, bid_nak, max_bid);
    bid_valid = '0;
    bid_retract = '0;
    bid_amt = '0;
  endtask

  task automatic start();
    C_start = 1'b1;
    tick();
    C_start = 1'b0;
    $display("start -> ready=%0b err=%0d", ready, err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_balance", balance, 0);
    chk("rst_max_bid", max_bid, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_ack_nak", {bid_ack, bid_nak}, 0);
    reset_n = 1'b1;
    tick();

    // Config flow and command errors
    cmd(4'd3, {16'd1, 16'd100});  chk("setbal_err", err, 0);
    cmd(4'd3, {16'd5, 16'd7});    chk("setbal_badidx_err", err, 4);
    cmd(4'd9, 32'd0);             chk("bad_op_err", err, 2);
    cmd(4'd4, 32'd4);             chk("settimer_err", err, 0);
    cmd(4'd2, 32'hA5);            chk("lock_ready", ready, 1);
    cmd(4'd6, 32'd1);             chk("fee_locked_err", err, 1);
    chk("bal1_kept", bal(1), 100);
    cmd(4'd2, 32'h11);            chk("relock_err", err, 1);
    cmd(4'd1, 32'h11);            chk("unlock_badkey_err", err, 3);
    chk("unlock_badkey_ready", ready, 1);
    cmd(4'd1, 32'hA5);            chk("unlock_err", err, 0);
    chk("unlock_ready", ready, 0);

    // Basic round: bidder0 10, bidder2 20, fee 1
    cmd(4'd3, {16'd0, 16'd100});
    cmd(4'd3, {16'd2, 16'd100});
    cmd(4'd6, 32'd1);             chk("fee_unlocked_err", err, 0);
    cmd(4'd2, 32'hA5);
    start();                      chk("start_ready", ready, 0);
    bid(0, 16'd10); bid_cycle();
    chk("r1_ack0", bid_ack, 3'b001);
    chk("r1_max10", max_bid, 10);
    chk("r1_bal0_fee", bal(0), 99);
    bid(2, 16'd20); bid_cycle();
    chk("r1_ack2", bid_ack, 3'b100);
    chk("r1_max20", max_bid, 20);
    bid_cycle();
    chk("r1_idle_ack", {bid_ack, bid_nak}, 0);
    bid_cycle();
    chk("r1_round_over", round_over, 1);
    chk("r1_settle_winv", win_valid, 0);
    tick();
    chk("r1_round_over_pulse", round_over, 0);
    chk("r1_win_valid", win_valid, 1);
    chk("r1_win_idx", win_idx, 2);
    chk("r1_max_bid", max_bid, 20);
    chk("r1_bal2", bal(2), 79);
    chk("r1_bal0", bal(0), 99);
    chk("r1_ready", ready, 1);

    // Same-cycle bids 30/30/25: tie to lowest index
    start();
    chk("r2_win_cleared", win_valid, 0);
    chk("r2_max_cleared", max_bid, 0);
    bid(0, 16'd30); bid(1, 16'd30); bid(2, 16'd25); bid_cycle();
    chk("r2_ack", bid_ack, 3'b001);
    chk("r2_nak", bid_nak, 3'b110);
    chk("r2_max", max_bid, 30);
    bid_cycle(); bid_cycle(); bid_cycle();
    tick();
    chk("r2_win_idx", win_idx, 0);
    chk("r2_bal0", bal(0), 68);
    chk("r2_bal1", bal(1), 100);

    // Insufficient funds, then exact funds accepted
    cmd(4'd1, 32'hA5);
    cmd(4'd3, {16'd1, 16'd5});
    cmd(4'd2, 32'hA5);
    start();
    bid(1, 16'd5); bid_cycle();
    chk("r3_funds_nak", bid_nak, 3'b010);
    chk("r3_funds_noack", bid_ack, 3'b000);
    bid(1, 16'd4); bid_cycle();
    chk("r3_exact_ack", bid_ack, 3'b010);
    chk("r3_bal1_fee", bal(1), 4);
    bid_cycle(); bid_cycle();
    tick();
    chk("r3_win_idx", win_idx, 1);
    chk("r3_bal1", bal(1), 0);

    // Mask 3'b101 blocks bidder1
    cmd(4'd1, 32'hA5);
    cmd(4'd3, {16'd1, 16'd100});
    cmd(4'd5, 32'h5);
    cmd(4'd2, 32'hA5);
    start();
    bid(1, 16'd10); bid_cycle();
    chk("r4_mask_nak", bid_nak, 3'b010);
    chk("r4_mask_max", max_bid, 0);
    bid(2, 16'd12); bid_cycle();
    chk("r4_ack2", bid_ack, 3'b100);
    bid_cycle(); bid_cycle();
    tick();
    chk("r4_win_idx", win_idx, 2);
    chk("r4_bal2", bal(2), 66);

    // Retract by leader, rejected retract from non-leader
    start();
    bid(0, 16'd10); bid_cycle();
    chk("r5_ack0", bid_ack, 3'b001);
    bid_retract = 3'b101; bid_cycle();
    chk("r5_retract_max", max_bid, 0);
    chk("r5_retract_nak", bid_nak, 3'b100);
    chk("r5_retract_ack", bid_ack, 3'b000);
    bid_cycle(); bid_cycle();
    chk("r5_round_over", round_over, 1);
    tick();
    chk("r5_win_valid", win_valid, 0);
    chk("r5_bal0_norefund", bal(0), 67);

    // Zero timer start is refused
    cmd(4'd1, 32'hA5);
    cmd(4'd4, 32'd0);
    cmd(4'd2, 32'hA5);
    start();
    chk("t0_err", err, 5);
    chk("t0_ready", ready, 1);
    tick();
    chk("t0_err_clear", err, 0);

    // Reset in the middle of a round
    cmd(4'd1, 32'hA5);
    cmd(4'd4, 32'd4);
    cmd(4'd2, 32'hA5);
    start();
    bid(0, 16'd10); bid_cycle();
    chk("rm_ack_before", bid_ack, 3'b001);
    reset_n = 1'b0;
    #1;
    chk("rm_ready", ready, 0);
    chk("rm_outputs", {bid_ack, bid_nak, round_over, win_valid, win_idx, max_bid, err}, 0);
    chk("rm_balance", balance, 0);
    tick();
    reset_n = 1'b1;
    cmd(4'd6, 32'd2);             chk("rm_unlocked", err, 0);
    cmd(4'd2, 32'h3C);            chk("rm_lock", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bidn_round_ctrl.md
Name: bidn_round_ctrl

Overview:
- Parametrised N-bidder auction round controller; next generation of the three-bidder bids22 controller.
- Host configures it through the C_data/C_op command port while unlocked, locks it, then starts timed bidding rounds.
- Adds a configurable bidder count and widths, a per-bidder enable mask, a per-bid fee and same-cycle multi-bid resolution.
- Sits between the host command bus and the bidder agents; it is the DUV for the top-level random-stimulus bench.

Parameters:
NUM_BIDDERS, 3, number of bidder channels (2..16)
DATA_W, 32, width of C_data
VALUE_W, 16, width of bid amounts, balances, fee and max_bid
TIMER_W, 16, width of the round-length counter

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
C_data  in  DATA_W  command operand
C_op  in  4  command opcode, sampled every cycle
C_start  in  1  round start request
bid_valid  in  NUM_BIDDERS  per-bidder bid strobe
bid_amt  in  NUM_BIDDERS*VALUE_W  flattened bid amounts; bidder i uses slice i
bid_retract  in  NUM_BIDDERS  per-bidder retract strobe
bid_ack  out  NUM_BIDDERS  one-cycle pulse, bid accepted
bid_nak  out  NUM_BIDDERS  one-cycle pulse, bid or retract rejected
balance  out  NUM_BIDDERS*VALUE_W  flattened current balances
ready  out  1  high in LOCKED_IDLE
round_over  out  1  one-cycle pulse in SETTLE
win_valid  out  1  last round produced a winner
win_idx  out  $clog2(NUM_BIDDERS)  winning bidder index
max_bid  out  VALUE_W  current or final maximum bid
err  out  3  command error code, valid for one cycle

Behaviour:
- Reset values (async): state=UNLOCKED, key=0, timer_cfg=0, fee=0, mask=all ones, balances=0, all outputs 0.
- States: UNLOCKED, LOCKED_IDLE, BIDDING, SETTLE.
- Opcodes:
  - 0 NOP.
  - 1 UNLOCK: C_data==key -> UNLOCKED; otherwise err=3.
  - 2 LOCK: key<=C_data, go to LOCKED_IDLE.
  - 3 SET_BAL: balance[C_data[DATA_W-1:VALUE_W] mod-checked index]<=C_data[VALUE_W-1:0]; an index >= NUM_BIDDERS gives err=4.
  - 4 SET_TIMER: timer_cfg<=C_data[TIMER_W-1:0].
  - 5 SET_MASK: mask<=C_data[NUM_BIDDERS-1:0].
  - 6 SET_FEE: fee<=C_data[VALUE_W-1:0].
  - 7..15: err=2.
- Command error rules:
  - Opcodes 3..6 issued while not UNLOCKED -> err=1, state unchanged.
  - LOCK while already locked -> err=1.
  - err=0 otherwise.
- err is registered, appearing the cycle after the command.
- C_start in LOCKED_IDLE:
  - timer_cfg==0 -> err=5, stay in LOCKED_IDLE.
  - Otherwise clear max_bid, clear the leader and win_valid, load the counter with timer_cfg, go to BIDDING.
- C_start in any other state is ignored.
- BIDDING, each cycle, bidder i with bid_valid[i] is eligible only if all of:
  - mask[i]=1
  - amt_i > max_bid
  - balance[i] >= amt_i + fee, compared at VALUE_W+1 bits with no wrap
- Ineligible bidders get bid_nak[i].
- Among eligible bidders the highest amt wins the cycle; ties go to the lowest index.
  - The cycle winner gets bid_ack, balance -= fee, max_bid<=amt, leader<=i.
  - The other eligible bidders get bid_nak.
- bid_retract[i]:
  - Accepted only from the current leader with no same-cycle bid_valid[i]: max_bid<=0, leader cleared, no fee refund.
  - Otherwise bid_nak[i].
  - Bids from others in the same cycle are evaluated against the pre-retract max_bid.
- The counter decrements every BIDDING cycle; bids are evaluated in the cycle the counter reads 1, then the state goes to SETTLE.
- A round therefore lasts exactly timer_cfg cycles.
- SETTLE (one cycle):
  - round_over=1.
  - If a leader exists: balance[leader] -= max_bid, win_valid=1, win_idx=leader.
  - Then go to LOCKED_IDLE.
- win_valid, win_idx and max_bid hold until the next accepted C_start.
- Commands are ignored during BIDDING and SETTLE; UNLOCK there gives err=1.
- reset_n asserted mid-round aborts the round immediately; all state returns to reset values.
- bid_ack and bid_nak are combinational from the registered decision, i.e. they are the registered outputs of the evaluation cycle, latency 1.

Test Plan:
- Config flow: SET_BAL bidder1=100, SET_TIMER=4, LOCK key=0xA5, then SET_FEE -> err=1 and balance[1] stays 100; UNLOCK 0xA5 -> UNLOCKED, err=0.
- Basic round: balances 100/100/100, fee=1, bidder0 bids 10 then bidder2 bids 20 -> ack both; settle gives round_over pulse, win_idx=2, max_bid=20, balance[2]=79, balance[0]=99.
- Same-cycle bids 30/30/25 -> bidder0 acked, bidders 1 and 2 nak'd, max_bid=30.
- Insufficient funds and mask: balance[1]=5 with bid 5 and fee 1 -> nak; mask=3'b101 and bidder1 bids -> nak.
- Retract: leader bidder0 retracts -> max_bid=0; a non-leader retract -> nak; no further bids -> win_valid=0 at settle.
- Edge cases: timer=0 with C_start -> err=5, ready stays high; reset_n low mid-BIDDING -> all outputs 0 and state UNLOCKED.
